// File: rtl/sprite_buf_pkg.sv
// Shared definitions for the sprite buffer writer: FSM state encoding,
// default geometry and a constant-coefficient row-base helper.
package sprite_buf_pkg;

  localparam int unsigned DEF_IMG_W  = 80;
  localparam int unsigned DEF_IMG_H  = 80;
  localparam int unsigned DEF_ADDR_W = 17;
  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned OFF_W      = 10;  // width of the x/y origin inputs

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Row base y*k for a constant k, written as a shift-add over the bits of y.
  // With k fixed at elaboration this reduces to a handful of adders; it is
  // evaluated once per frame, when the origin is latched.
  function automatic logic [31:0] const_mul(input logic [OFF_W-1:0] y,
                                            input int unsigned     k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < int'(OFF_W); i++) begin
      if (y[i]) acc = acc + (32'(k) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sprite_buf_writer_if.sv
// Control, pixel-stream and RAM write-port signals of the sprite buffer writer.
interface sprite_buf_writer_if
  import sprite_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  // frame control
  logic              start;
  logic [OFF_W-1:0]  x_off;
  logic [OFF_W-1:0]  y_off;
  logic              busy;
  logic              done;
  logic              err;

  // pixel stream
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  // RAM write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Source side: loader / generator / testbench.
  modport master (
    output start, x_off, y_off, in_valid, in_data, in_last,
    input  busy, done, err, in_ready, wr_en, wr_addr, wr_data
  );

  // Writer side.
  modport slave (
    input  start, x_off, y_off, in_valid, in_data, in_last,
    output busy, done, err, in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/sprite_buf_writer_wrap_counter.sv
// Modulo-MAX up counter with synchronous clear and load. wrap flags the
// step that takes the count from MAX-1 back to 0.
module wrap_counter #(
  parameter  int unsigned MAX = 80,
  localparam int unsigned CW  = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic at_top;

  assign at_top = (count == CW'(MAX - 1));
  assign wrap   = en && at_top;

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is always assigned with <= so every register in the
    // design samples the same pre-edge values, independent of block order.
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en) begin
      count <= at_top ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/sprite_buf_writer.sv
// Raster-order writer for an offset-addressed W x H frame buffer. Stream
// pixel (c, r) is written to ((c+x0) mod W) + W*((r+y0) mod H). The column
// term is one conditional subtract; the row term is an incrementally
// advanced row base, so no multiplier or divider sits in the per-beat path.
module sprite_buf_writer
  import sprite_buf_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic               clk,
  input logic               rst_n,
  sprite_buf_writer_if.slave bus
);

  localparam int unsigned CXW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RYW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_FILL = ST_FILL;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]        state;
  logic              err_q;

  // latched origin and running row base
  logic [CXW-1:0]    x0;
  logic [RYW-1:0]    y0;
  logic [ADDR_W-1:0] rb;

  // counters
  logic [CXW-1:0]    cx;
  logic [RYW-1:0]    ry;
  logic              cx_wrap;
  logic              ry_wrap;

  // per-beat decode
  logic              take_start;
  logic              accept;
  logic              frame_end;
  logic              x_ok;
  logic              y_ok;
  logic [CXW:0]      x_sum;
  logic [CXW:0]      xw;
  logic [RYW:0]      y_sum;
  logic [RYW:0]      yw;
  logic [ADDR_W-1:0] addr;

  // registered outputs
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign take_start = (state == S_IDLE) && bus.start;
  assign accept     = (state == S_FILL) && bus.in_valid;
  assign frame_end  = ry_wrap;  // column and row both at their last value

  assign x_ok = (32'(bus.x_off) < 32'(IMG_W));
  assign y_ok = (32'(bus.y_off) < 32'(IMG_H));

  // Column and row coordinates in buffer space: each is one conditional subtract.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    x_sum = {1'b0, cx} + {1'b0, x0};
    xw    = x_sum;
    if (x_sum >= (CXW+1)'(IMG_W)) xw = x_sum - (CXW+1)'(IMG_W);
    y_sum = {1'b0, ry} + {1'b0, y0};
    yw    = y_sum;
    if (y_sum >= (RYW+1)'(IMG_H)) yw = y_sum - (RYW+1)'(IMG_H);
    addr  = ADDR_W'(xw) + rb;
  end

  wrap_counter #(.MAX(IMG_W)) u_cx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .clr   (take_start),
    .load  (1'b0),
    .value ('0),
    .count (cx),
    .wrap  (cx_wrap)
  );

  wrap_counter #(.MAX(IMG_H)) u_ry (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cx_wrap),
    .clr   (take_start),
    .load  (1'b0),
    .value ('0),
    .count (ry),
    .wrap  (ry_wrap)
  );

  // Frame sequencing and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_FILL;
            err_q <= !(x_ok && y_ok);
          end
        end
        S_FILL: begin
          if (accept && (frame_end || bus.in_last)) begin
            state <= S_DONE;
            // last flag missing on the final pixel, or present too early
            if (frame_end != bus.in_last) err_q <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Origin latch and row base: seeded at start, +IMG_W at each row end,
  // back to 0 when the buffer row being left is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0;
      y0 <= '0;
      rb <= '0;
    end else if (take_start) begin
      x0 <= x_ok ? CXW'(bus.x_off) : '0;
      y0 <= y_ok ? RYW'(bus.y_off) : '0;
      rb <= y_ok ? ADDR_W'(const_mul(bus.y_off, IMG_W)) : '0;
    end else if (cx_wrap) begin
      rb <= (yw == (RYW+1)'(IMG_H - 1)) ? '0 : rb + ADDR_W'(IMG_W);
    end
  end

  // RAM write port: one-cycle registered copy of each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= addr;
        wr_data_q <= bus.in_data;
      end
    end
  end

  assign bus.in_ready = (state == S_FILL);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.err      = err_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_sprite_buf_writer.sv
// Directed bench for sprite_buf_writer on an 80x80 buffer.
module tb_sprite_buf_writer;

  localparam int W      = 80;
  localparam int H      = 80;
  localparam int DEPTH  = W * H;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  int wq[$];      // write addresses in order
  int dq[$];      // write data in order
  int ref_q[$];   // gap-free reference address sequence

  sprite_buf_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sprite_buf_writer #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Capture writes and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq.push_back(int'(bus.wr_addr));
      dq.push_back(int'(bus.wr_data));
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_addr(input int i, input int x0, input int y0);
    return ((i % W) + x0) % W + W * (((i / W) + y0) % H);
  endfunction

  task automatic clear_log();
    wq.delete();
    dq.delete();
    done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int x, input int y);
    bus.start = 1'b1;
    bus.x_off = 10'(x);
    bus.y_off = 10'(y);
    step();
    bus.start = 1'b0;
  endtask

  // Stream n_beats pixels (data = index); in_last on last_beat; optional
  // random idle cycles; a stray start pulse on beat pulse_beat.
  task automatic send_frame(input int n_beats, input int last_beat,
                            input bit gaps, input int pulse_beat);
    int i;
    int w;
    i = 0;
    while (i < n_beats) begin
      if (gaps && ($urandom_range(1, 0) == 1)) begin
        bus.in_valid = 1'b0;
        step();
        continue;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(i);
      bus.in_last  = (i == last_beat);
      if (i == pulse_beat) begin
        bus.start = 1'b1;
        bus.x_off = 10'd30;
        bus.y_off = 10'd5;
      end
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 20) begin
        step();
        w++;
      end
      if (w == 20) begin
        check("ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.start    = 1'b0;
        return;
      end
      step();
      bus.start = 1'b0;
      i++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic verify_frame(input string tag, input int n, input int x0, input int y0);
    int bad_a;
    int bad_d;
    bad_a = 0;
    bad_d = 0;
    check({tag, "_writes"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < wq.size() && i < n; i++) begin
      if (wq[i] != model_addr(i, x0, y0)) bad_a++;
      if (dq[i] != (i & 12'hFFF)) bad_d++;
    end
    check({tag, "_addr_errs"}, 32'(bad_a), 32'd0);
    check({tag, "_data_errs"}, 32'(bad_d), 32'd0);
  endtask

  // End-of-frame timing: called right after the final accepting edge.
  task automatic check_frame_end(input string tag, input logic exp_err);
    check({tag, "_done_k1"},  32'(bus.done),     32'd1);
    check({tag, "_wren_k1"},  32'(bus.wr_en),    32'd1);
    check({tag, "_ready_k1"}, 32'(bus.in_ready), 32'd0);
    step();
    check({tag, "_busy_k2"},  32'(bus.busy),     32'd0);
    check({tag, "_done_k2"},  32'(bus.done),     32'd0);
    check({tag, "_err"},      32'(bus.err),      32'(exp_err));
    check({tag, "_done_cnt"}, 32'(done_cnt),     32'd1);
  endtask

  initial begin
    int bad;
    bus.start    = 1'b0;
    bus.x_off    = '0;
    bus.y_off    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // reset state
    repeat (2) step();
    check("rst_ready",   32'(bus.in_ready), 32'd0);
    check("rst_wr_en",   32'(bus.wr_en),    32'd0);
    check("rst_done",    32'(bus.done),     32'd0);
    check("rst_err",     32'(bus.err),      32'd0);
    check("rst_busy",    32'(bus.busy),     32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr),  32'd0);
    check("rst_wr_data", 32'(bus.wr_data),  32'd0);
    rst_n = 1'b1;
    step();
    check("idle_ready",  32'(bus.in_ready), 32'd0);

    // 1: origin 0,0, full frame without gaps
    clear_log();
    do_start(0, 0);
    check("t1_ready_after_start", 32'(bus.in_ready), 32'd1);
    check("t1_busy_after_start",  32'(bus.busy),     32'd1);
    send_frame(DEPTH, DEPTH - 1, 1'b0, -1);
    check_frame_end("t1", 1'b0);
    verify_frame("t1", DEPTH, 0, 0);

    // 2: origin 45,70 with hand-computed spot addresses
    clear_log();
    do_start(45, 70);
    send_frame(DEPTH, DEPTH - 1, 1'b0, -1);
    check_frame_end("t2", 1'b0);
    verify_frame("t2", DEPTH, 45, 70);
    if (wq.size() == DEPTH) begin
      check("t2_beat0",    32'(wq[0]),    32'd5645);
      check("t2_beat35",   32'(wq[35]),   32'd5600);
      check("t2_beat800",  32'(wq[800]),  32'd45);
      check("t2_beat6399", 32'(wq[6399]), 32'd5564);
    end else begin
      check("t2_spot_len", 32'(wq.size()), 32'(DEPTH));
    end
    ref_q = wq;

    // 3: same origin with random idle cycles
    clear_log();
    do_start(45, 70);
    send_frame(DEPTH, DEPTH - 1, 1'b1, -1);
    check_frame_end("t3", 1'b0);
    check("t3_writes", 32'(wq.size()), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < wq.size() && i < ref_q.size(); i++) begin
      if (wq[i] != ref_q[i]) bad++;
    end
    check("t3_vs_gapfree", 32'(bad), 32'd0);

    // 4: early last on beat 99
    clear_log();
    do_start(0, 0);
    send_frame(100, 99, 1'b0, -1);
    check_frame_end("t4", 1'b1);
    verify_frame("t4", 100, 0, 0);

    // 5: asynchronous reset mid-frame, then restart from origin 0,0
    clear_log();
    do_start(0, 0);
    send_frame(3001, -1, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_wr_en", 32'(bus.wr_en),    32'd0);
    check("t5_rst_ready", 32'(bus.in_ready), 32'd0);
    check("t5_rst_busy",  32'(bus.busy),     32'd0);
    step();
    rst_n = 1'b1;
    step();
    clear_log();
    do_start(0, 0);
    send_frame(8, 7, 1'b0, -1);
    check_frame_end("t5", 1'b1);
    verify_frame("t5", 8, 0, 0);

    // 6a: stray start during FILL is ignored
    clear_log();
    do_start(0, 0);
    send_frame(DEPTH, DEPTH - 1, 1'b0, 10);
    check_frame_end("t6a", 1'b0);
    verify_frame("t6a", DEPTH, 0, 0);

    // 6b: out-of-range x origin falls back to 0 and flags err
    clear_log();
    do_start(80, 0);
    check("t6b_err_at_start", 32'(bus.err), 32'd1);
    send_frame(10, 9, 1'b0, -1);
    check_frame_end("t6b", 1'b1);
    verify_frame("t6b", 10, 0, 0);
    if (wq.size() > 0) check("t6b_first_addr", 32'(wq[0]), 32'd0);

    // 7: a clean start clears the sticky error
    clear_log();
    do_start(1, 1);
    check("t7_err_cleared", 32'(bus.err), 32'd0);
    send_frame(3, 2, 1'b0, -1);
    check_frame_end("t7", 1'b1);
    verify_frame("t7", 3, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
